// File: rtl/spmv_kernel_ctrl_bank.sv
// rtl/spmv_kernel_ctrl_bank.sv - per-kernel control/status register bank for SpMV kernels
// Each kernel runs an IDLE/REQ/RUN FSM with locked config, abort, W1C status and a RUN-cycle counter.
module spmv_kernel_ctrl_bank #(
  parameter int          NUM_KERNEL = 4,
  parameter int          NUM_CFG    = 4,
  parameter int          ADDR_W     = 10,
  parameter int          STRIDE     = 32,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               reg_en,
  input  logic                               reg_we,
  input  logic [ADDR_W-1:0]                  reg_addr,
  input  logic [31:0]                        reg_din,
  output logic [31:0]                        reg_dout,
  output logic [32*NUM_CFG*NUM_KERNEL-1:0]   cfg_out,
  output logic [NUM_KERNEL-1:0]              kernel_start,
  input  logic [NUM_KERNEL-1:0]              kernel_ready,
  input  logic [NUM_KERNEL-1:0]              kernel_done,
  output logic [NUM_KERNEL-1:0]              kernel_abort,
  output logic                               irq
);

  localparam int OFF_W = $clog2(STRIDE);
  localparam int K_W   = ADDR_W - OFF_W;
  localparam int WO_W  = OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RUN = 2'd2} state_t;

  state_t                      r_state  [NUM_KERNEL];
  logic [31:0]                 r_cycles [NUM_KERNEL];
  logic [31:0]                 r_cfg    [NUM_KERNEL][NUM_CFG];
  logic [NUM_KERNEL-1:0]       r_irq_en;
  logic [NUM_KERNEL-1:0]       r_done;
  logic [NUM_KERNEL-1:0]       r_err;
  logic [NUM_KERNEL-1:0]       r_start;
  logic [NUM_KERNEL-1:0]       r_abort;
  logic [31:0]                 r_dout;

  logic [K_W-1:0]              w_k;
  logic [WO_W-1:0]             w_woff;
  logic                        w_wr;
  logic                        w_unused;
  logic [NUM_KERNEL-1:0]       w_busy;
  logic [NUM_KERNEL-1:0]       w_ctrl_wr;
  logic [NUM_KERNEL-1:0]       w_stat_wr;
  logic [NUM_KERNEL-1:0][NUM_CFG-1:0] w_cfg_wr;
  logic [NUM_KERNEL-1:0]       w_abort_go;
  logic [NUM_KERNEL-1:0]       w_err_set;
  logic [NUM_KERNEL-1:0]       w_done_set;
  logic [31:0]                 w_rdata;

  assign w_k      = reg_addr[ADDR_W-1:OFF_W];
  assign w_woff   = reg_addr[OFF_W-1:2];
  assign w_wr     = reg_en & reg_we;
  assign w_unused = ^reg_addr[1:0];

  always_comb begin
    w_ctrl_wr = '0;
    w_stat_wr = '0;
    w_cfg_wr  = '0;
    for (int i = 0; i < NUM_KERNEL; i++) begin
      if (w_wr && (w_k == K_W'(i))) begin
        w_ctrl_wr[i] = (w_woff == WO_W'(0));
        w_stat_wr[i] = (w_woff == WO_W'(1));
        for (int j = 0; j < NUM_CFG; j++)
          w_cfg_wr[i][j] = (w_woff == WO_W'(3 + j));
      end
    end
  end

  // Abort beats start and beats a coincident kernel_done; hardware sets beat W1C clears.
  always_comb begin
    for (int i = 0; i < NUM_KERNEL; i++) begin
      w_busy[i]     = (r_state[i] != S_IDLE);
      w_abort_go[i] = w_ctrl_wr[i] & w_busy[i] & reg_din[1];
      w_err_set[i]  = w_busy[i] & ((|w_cfg_wr[i]) | (w_ctrl_wr[i] & (reg_din[0] | reg_din[1])));
      w_done_set[i] = (r_state[i] == S_RUN) & kernel_done[i] & ~w_abort_go[i];
    end
  end

  always_comb begin
    w_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < NUM_KERNEL; i++) begin
      if (w_k == K_W'(i)) begin
        if (w_woff == WO_W'(0))      w_rdata = {29'd0, r_irq_en[i], 2'd0};
        else if (w_woff == WO_W'(1)) w_rdata = {26'd0, r_state[i], 1'b0, r_err[i], r_done[i], w_busy[i]};
        else if (w_woff == WO_W'(2)) w_rdata = r_cycles[i];
        for (int j = 0; j < NUM_CFG; j++)
          if (w_woff == WO_W'(3 + j)) w_rdata = r_cfg[i][j];
      end
    end
    if (w_k == K_W'(NUM_KERNEL)) begin
      if (w_woff == WO_W'(0)) begin
        w_rdata = VERSION;
      end else if (w_woff == WO_W'(1)) begin
        w_rdata = '0;
        w_rdata[NUM_KERNEL-1:0] = r_done;
      end else if (w_woff == WO_W'(2)) begin
        w_rdata = 32'(NUM_KERNEL) | (32'(NUM_CFG) << 8);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_KERNEL; i++) begin
        r_state[i]  <= S_IDLE;
        r_cycles[i] <= '0;
        for (int j = 0; j < NUM_CFG; j++) r_cfg[i][j] <= '0;
      end
      r_irq_en <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_start  <= '0;
      r_abort  <= '0;
      r_dout   <= '0;
    end else begin
      r_abort <= '0;
      if (reg_en && !reg_we) r_dout <= w_rdata;
      for (int i = 0; i < NUM_KERNEL; i++) begin
        if (w_ctrl_wr[i]) r_irq_en[i] <= reg_din[2];
        for (int j = 0; j < NUM_CFG; j++)
          if (w_cfg_wr[i][j] && !w_busy[i]) r_cfg[i][j] <= reg_din;
        r_err[i]  <= w_err_set[i]  | (r_err[i]  & ~(w_stat_wr[i] & reg_din[2]));
        r_done[i] <= w_done_set[i] | (r_done[i] & ~(w_stat_wr[i] & reg_din[1]));
        if (w_abort_go[i]) begin
          r_state[i] <= S_IDLE;
          r_start[i] <= 1'b0;
          r_abort[i] <= 1'b1;
        end else begin
          case (r_state[i])
            S_IDLE: if (w_ctrl_wr[i] && reg_din[0]) begin
              r_state[i]  <= S_REQ;
              r_start[i]  <= 1'b1;
              r_cycles[i] <= '0;
            end
            S_REQ: if (kernel_ready[i]) begin
              r_state[i] <= S_RUN;
              r_start[i] <= 1'b0;
            end
            S_RUN: begin
              if (r_cycles[i] != 32'hFFFF_FFFF) r_cycles[i] <= r_cycles[i] + 32'd1;
              if (kernel_done[i]) r_state[i] <= S_IDLE;
            end
            default: begin
              r_state[i] <= S_IDLE;
              r_start[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_KERNEL; gi++) begin : g_cfg_k
    for (genvar gj = 0; gj < NUM_CFG; gj++) begin : g_cfg_w
      assign cfg_out[32*(gi*NUM_CFG+gj) +: 32] = r_cfg[gi][gj];
    end
  end

  assign reg_dout     = r_dout;
  assign kernel_start = r_start;
  assign kernel_abort = r_abort;
  assign irq          = |(r_done & r_irq_en);

endmodule

// File: tb/tb_spmv_kernel_ctrl_bank.sv
// tb/tb_spmv_kernel_ctrl_bank.sv - directed self-checking bench for spmv_kernel_ctrl_bank
module tb_spmv_kernel_ctrl_bank;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          reg_en;
  logic          reg_we;
  logic [9:0]    reg_addr;
  logic [31:0]   reg_din;
  logic [31:0]   reg_dout;
  logic [511:0]  cfg_out;
  logic [3:0]    kernel_start;
  logic [3:0]    kernel_ready;
  logic [3:0]    kernel_done;
  logic [3:0]    kernel_abort;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 aclk = ~aclk;

  spmv_kernel_ctrl_bank dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .reg_en       (reg_en),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .reg_dout     (reg_dout),
    .cfg_out      (cfg_out),
    .kernel_start (kernel_start),
    .kernel_ready (kernel_ready),
    .kernel_done  (kernel_done),
    .kernel_abort (kernel_abort),
    .irq          (irq)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [9:0] a, input logic [31:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
    string       t;
    logic [31:0] e;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_en = 1'b0;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    chk(t, reg_dout, e);
  endtask

  task automatic pulse_ready(input int k);
    kernel_ready[k] = 1'b1;
    tick();
    kernel_ready[k] = 1'b0;
  endtask

  task automatic pulse_done(input int k);
    kernel_done[k] = 1'b1;
    tick();
    kernel_done[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1; reg_en = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_din = '0;
    kernel_ready = '0; kernel_done = '0;
    #2 aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // reset defaults
    for (int a = 0; a <= 24; a += 4) reg_read(10'(a), 32'd0, $sformatf("rst_k0_%02h", a));
    reg_read(10'h080, 32'h0002_0000, "version");
    reg_read(10'h084, 32'd0, "done_sum_rst");
    reg_read(10'h088, 32'h0000_0404, "geometry");
    reg_read(10'h3FC, 32'hDEAD_BEEF, "unmapped");
    reg_read(10'h01C, 32'hDEAD_BEEF, "unmapped_k0_gap");
    chk("start_rst", 32'(kernel_start), 32'd0);
    chk("irq_rst", 32'(irq), 32'd0);

    // kernel 1 config and handshake
    reg_write(10'h02C, 32'h1234);
    chk("cfg_k1_w0", cfg_out[32*4 +: 32], 32'h1234);
    reg_write(10'h020, 32'h5);
    chk("start_k1", 32'(kernel_start), 32'h2);
    reg_read(10'h020, 32'h4, "ctrl_k1");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("start_hold_%0d", c), 32'(kernel_start), 32'h2);
    end
    pulse_ready(1);
    chk("start_k1_drop", 32'(kernel_start), 32'd0);
    reg_read(10'h024, 32'h21, "status_k1_run");
    repeat (8) tick();
    pulse_done(1);
    chk("irq_k1_done", 32'(irq), 32'd1);
    reg_read(10'h024, 32'h02, "status_k1_done");
    reg_read(10'h028, 32'd10, "cycles_k1");
    reg_read(10'h084, 32'h2, "done_sum_k1");
    reg_write(10'h024, 32'h2);
    chk("irq_k1_clr", 32'(irq), 32'd0);
    reg_read(10'h024, 32'd0, "status_k1_clr");

    // kernel 2 locking
    reg_write(10'h04C, 32'hAAAA);
    reg_write(10'h040, 32'h1);
    pulse_ready(2);
    reg_write(10'h04C, 32'h5555);
    chk("cfg_k2_locked", cfg_out[32*8 +: 32], 32'hAAAA);
    reg_write(10'h040, 32'h1);
    chk("start_k2_busy", 32'(kernel_start), 32'd0);
    reg_read(10'h044, 32'h25, "status_k2_locked");
    pulse_done(2);
    reg_read(10'h044, 32'h06, "status_k2_done_err");
    reg_write(10'h044, 32'h6);
    reg_read(10'h044, 32'd0, "status_k2_clr");

    // kernel 0 abort
    reg_write(10'h000, 32'h1);
    chk("start_k0", 32'(kernel_start), 32'h1);
    reg_write(10'h000, 32'h2);
    chk("abort_k0_pulse", 32'(kernel_abort), 32'h1);
    chk("start_k0_abort", 32'(kernel_start), 32'd0);
    tick();
    chk("abort_k0_end", 32'(kernel_abort), 32'd0);
    reg_read(10'h004, 32'h04, "status_k0_abort");
    pulse_done(0);
    reg_read(10'h004, 32'h04, "status_k0_late_done");
    reg_write(10'h000, 32'h2);
    chk("abort_k0_idle", 32'(kernel_abort), 32'd0);
    reg_write(10'h004, 32'h4);
    reg_read(10'h004, 32'd0, "status_k0_clr");
    reg_write(10'h000, 32'h3);
    chk("start_wins_idle", 32'(kernel_start), 32'h1);
    chk("no_abort_idle", 32'(kernel_abort), 32'd0);
    reg_read(10'h004, 32'h11, "status_k0_req");
    reg_write(10'h000, 32'h3);
    chk("abort_wins_busy", 32'(kernel_abort), 32'h1);
    reg_read(10'h004, 32'h04, "status_k0_abort2");

    // kernel 3 W1C vs done race
    reg_write(10'h060, 32'h1);
    pulse_ready(3);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = 10'h064; reg_din = 32'h2;
    kernel_done[3] = 1'b1;
    tick();
    reg_en = 1'b0; reg_we = 1'b0; kernel_done[3] = 1'b0;
    reg_read(10'h064, 32'h02, "status_k3_race");
    reg_write(10'h064, 32'h2);
    reg_read(10'h064, 32'd0, "status_k3_clr");

    // asynchronous reset mid-RUN
    reg_write(10'h020, 32'h5);
    pulse_ready(1);
    pulse_done(1);
    reg_write(10'h020, 32'h5);
    pulse_ready(1);
    reg_write(10'h000, 32'h1);
    reg_read(10'h024, 32'h23, "status_k1_pre_rst");
    chk("irq_pre_rst", 32'(irq), 32'd1);
    chk("start_pre_rst", 32'(kernel_start), 32'h1);
    #2 aresetn = 1'b0;
    #1;
    chk("start_async_rst", 32'(kernel_start), 32'd0);
    chk("abort_async_rst", 32'(kernel_abort), 32'd0);
    chk("irq_async_rst", 32'(irq), 32'd0);
    chk("dout_async_rst", reg_dout, 32'd0);
    chk("cfg_async_rst", 32'(|cfg_out), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    reg_read(10'h024, 32'd0, "status_k1_post_rst");
    reg_read(10'h02C, 32'd0, "cfg_k1_post_rst");
    reg_read(10'h028, 32'd0, "cycles_k1_post_rst");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
